// File: rtl/rv32_pkg.sv
// Shared RV32 datapath constants and ALU operation codes.
package rv32_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SRA = 3'd7
    } alu_op_e;

endpackage

// File: rtl/operand_bypass.sv
// Single-operand forwarding mux: EX/MEM result beats MEM/WB result beats the held value.
module operand_bypass #(
    parameter int XLEN   = rv32_pkg::XLEN,
    parameter int REG_AW = rv32_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] src_addr,
    input  logic [XLEN-1:0]   held_data,
    input  logic              exm_we,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [XLEN-1:0]   exm_data,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   data
);

    always_comb begin
        data = held_data;
        // x0 is hardwired zero, so a write "to x0" must never be forwarded
        if (wb_we && wb_rd == src_addr && wb_rd != '0)
            data = wb_data;
        if (exm_we && exm_rd == src_addr && exm_rd != '0)
            data = exm_data;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard stall and stall counter.
// IDEX_BYPASS_EN: when defined, held operands are forwarded from EX/MEM and MEM/WB;
// otherwise decode stalls on any outstanding RAW dependency.
module id_ex_stage #(
    parameter int XLEN   = rv32_pkg::XLEN,
    parameter int REG_AW = rv32_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [REG_AW-1:0] in_rs1_addr,
    input  logic [REG_AW-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              in_num2_sel,
    input  logic [2:0]        in_alu_ctrl,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_reg_we,
    input  logic              in_mem_rd,
    input  logic              in_mem_wr,
    input  logic              exm_we,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [XLEN-1:0]   exm_data,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_imm,
    output logic              out_num2_sel,
    output logic [2:0]        out_alu_ctrl,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_reg_we,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic [XLEN-1:0]   out_rs1_data,
    output logic [XLEN-1:0]   out_rs2_data,
    output logic [31:0]       stall_cnt
);

    import rv32_pkg::*;

    logic              vld_p1;
    logic [XLEN-1:0]   pc_p1, imm_p1, rs1_data_p1, rs2_data_p1;
    logic [REG_AW-1:0] rs1_addr_p1, rs2_addr_p1, rd_p1;
    logic              num2_sel_p1, reg_we_p1, mem_rd_p1, mem_wr_p1;
    alu_op_e           alu_ctrl_p1;
    logic [31:0]       stall_cnt_r;

    logic hazard;
    logic capture;

    function automatic logic src_match(input logic we, input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] a1,
                                       input logic [REG_AW-1:0] a2);
        return we && rd != '0 && (rd == a1 || rd == a2);
    endfunction

    always_comb begin
        hazard = in_valid && src_match(vld_p1 && mem_rd_p1, rd_p1, in_rs1_addr, in_rs2_addr);
`ifndef IDEX_BYPASS_EN
        // without forwarding, any producer still in flight blocks the consumer
        hazard = hazard || (in_valid &&
                 (src_match(vld_p1 && reg_we_p1, rd_p1, in_rs1_addr, in_rs2_addr) ||
                  src_match(exm_we, exm_rd, in_rs1_addr, in_rs2_addr) ||
                  src_match(wb_we, wb_rd, in_rs1_addr, in_rs2_addr)));
`endif
    end

    assign in_ready = flush || (!hazard && (!vld_p1 || out_ready));
    assign capture  = in_valid && in_ready && !flush;

    // ---- ID -> EX register boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            pc_p1       <= '0;
            imm_p1      <= '0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            rs1_addr_p1 <= '0;
            rs2_addr_p1 <= '0;
            rd_p1       <= '0;
            num2_sel_p1 <= 1'b0;
            reg_we_p1   <= 1'b0;
            mem_rd_p1   <= 1'b0;
            mem_wr_p1   <= 1'b0;
            alu_ctrl_p1 <= ALU_ADD;
            stall_cnt_r <= '0;
        end else begin
            if (hazard && stall_cnt_r != 32'hFFFF_FFFF)
                stall_cnt_r <= stall_cnt_r + 32'd1;
            if (flush) begin
                vld_p1 <= 1'b0;
            end else if (capture) begin
                vld_p1      <= 1'b1;
                pc_p1       <= in_pc;
                imm_p1      <= in_imm;
                rs1_data_p1 <= in_rs1_data;
                rs2_data_p1 <= in_rs2_data;
                rs1_addr_p1 <= in_rs1_addr;
                rs2_addr_p1 <= in_rs2_addr;
                rd_p1       <= in_rd;
                num2_sel_p1 <= in_num2_sel;
                reg_we_p1   <= in_reg_we;
                mem_rd_p1   <= in_mem_rd;
                mem_wr_p1   <= in_mem_wr;
                alu_ctrl_p1 <= alu_op_e'(in_alu_ctrl);
            end else if (vld_p1 && out_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

`ifdef IDEX_BYPASS_EN
    operand_bypass #(.XLEN(XLEN), .REG_AW(REG_AW)) u_bypass_rs1 (
        .src_addr (rs1_addr_p1),
        .held_data(rs1_data_p1),
        .exm_we   (exm_we),
        .exm_rd   (exm_rd),
        .exm_data (exm_data),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .data     (out_rs1_data)
    );

    operand_bypass #(.XLEN(XLEN), .REG_AW(REG_AW)) u_bypass_rs2 (
        .src_addr (rs2_addr_p1),
        .held_data(rs2_data_p1),
        .exm_we   (exm_we),
        .exm_rd   (exm_rd),
        .exm_data (exm_data),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .data     (out_rs2_data)
    );
`else
    assign out_rs1_data = rs1_data_p1;
    assign out_rs2_data = rs2_data_p1;
`endif

    assign out_valid    = vld_p1;
    assign out_pc       = pc_p1;
    assign out_imm      = imm_p1;
    assign out_num2_sel = num2_sel_p1;
    assign out_alu_ctrl = alu_ctrl_p1;
    assign out_rd       = rd_p1;
    assign out_reg_we   = reg_we_p1;
    assign out_mem_rd   = mem_rd_p1;
    assign out_mem_wr   = mem_wr_p1;
    assign stall_cnt    = stall_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage against a transaction-level reference model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd;
    logic        in_num2_sel, in_reg_we, in_mem_rd, in_mem_wr;
    logic [2:0]  in_alu_ctrl;
    logic        exm_we, wb_we;
    logic [4:0]  exm_rd, wb_rd;
    logic [31:0] exm_data, wb_data;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_imm, out_rs1_data, out_rs2_data, stall_cnt;
    logic        out_num2_sel, out_reg_we, out_mem_rd, out_mem_wr;
    logic [2:0]  out_alu_ctrl;
    logic [4:0]  out_rd;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_num2_sel(in_num2_sel), .in_alu_ctrl(in_alu_ctrl),
        .in_rd(in_rd), .in_reg_we(in_reg_we), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
        .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
        .out_num2_sel(out_num2_sel), .out_alu_ctrl(out_alu_ctrl), .out_rd(out_rd),
        .out_reg_we(out_reg_we), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the single instruction currently held, plus the stall count.
    typedef struct packed {
        logic [31:0] pc, imm, rs1d, rs2d;
        logic [4:0]  rs1a, rs2a, rd;
        logic        sel, we, mrd, mwr;
        logic [2:0]  alu;
    } instr_t;

    logic        m_vld = 1'b0;
    instr_t      m_ins = '0;
    logic [31:0] m_cnt = '0;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic reads(input logic [4:0] r);
        return r != 5'd0 && (r == in_rs1_addr || r == in_rs2_addr);
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] held);
`ifdef IDEX_BYPASS_EN
        if (a != 0 && exm_we && exm_rd == a) return exm_data;
        if (a != 0 && wb_we && wb_rd == a) return wb_data;
`endif
        return held;
    endfunction

    function automatic logic model_stall();
        logic s;
        s = in_valid && m_vld && m_ins.mrd && reads(m_ins.rd);
`ifndef IDEX_BYPASS_EN
        if (in_valid && ((m_vld && m_ins.we && reads(m_ins.rd)) ||
                         (exm_we && reads(exm_rd)) || (wb_we && reads(wb_rd))))
            s = 1'b1;
`endif
        return s;
    endfunction

    // Called just after a falling edge with inputs already driven; returns after the next falling edge.
    task automatic step();
        logic st, rdy;
        #1;
        st  = model_stall();
        rdy = flush || (!st && (!m_vld || out_ready));
        check("in_ready",  {63'd0, in_ready}, {63'd0, rdy});
        check("out_valid", {63'd0, out_valid}, {63'd0, m_vld});
        check("out_pc",    {32'd0, out_pc}, {32'd0, m_ins.pc});
        check("ctrl",      {20'd0, out_imm, out_num2_sel, out_alu_ctrl, out_rd, out_reg_we, out_mem_rd, out_mem_wr},
                           {20'd0, m_ins.imm, m_ins.sel, m_ins.alu, m_ins.rd, m_ins.we, m_ins.mrd, m_ins.mwr});
        check("rs1_data",  {32'd0, out_rs1_data}, {32'd0, operand(m_ins.rs1a, m_ins.rs1d)});
        check("rs2_data",  {32'd0, out_rs2_data}, {32'd0, operand(m_ins.rs2a, m_ins.rs2d)});
        check("stall_cnt", {32'd0, stall_cnt}, {32'd0, m_cnt});
        @(posedge clk);
        if (rst) begin
            m_vld = 1'b0; m_ins = '0; m_cnt = '0;
        end else begin
            if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (flush) m_vld = 1'b0;
            else if (in_valid && rdy) begin
                m_vld = 1'b1;
                m_ins = '{pc: in_pc, imm: in_imm, rs1d: in_rs1_data, rs2d: in_rs2_data,
                          rs1a: in_rs1_addr, rs2a: in_rs2_addr, rd: in_rd, sel: in_num2_sel,
                          we: in_reg_we, mrd: in_mem_rd, mwr: in_mem_wr, alu: in_alu_ctrl};
            end else if (m_vld && out_ready) m_vld = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; flush = 0; in_valid = 0; out_ready = 0;
        in_pc = 0; in_rs1_addr = 0; in_rs2_addr = 0; in_rs1_data = 0; in_rs2_data = 0;
        in_imm = 0; in_num2_sel = 0; in_alu_ctrl = 0; in_rd = 0;
        in_reg_we = 0; in_mem_rd = 0; in_mem_wr = 0;
        exm_we = 0; exm_rd = 0; exm_data = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic load);
        in_valid = 1; in_pc = pc; in_rs1_addr = rs1; in_rs2_addr = rs2; in_rd = rd;
        in_rs1_data = $urandom; in_rs2_data = $urandom; in_imm = $urandom;
        in_num2_sel = load; in_alu_ctrl = 3'd0; in_reg_we = 1; in_mem_rd = load; in_mem_wr = 0;
    endtask

    task automatic rand_inputs();
        rst = ($urandom_range(0, 99) == 0);
        flush = ($urandom_range(0, 19) == 0);
        in_valid = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        in_pc = $urandom; in_imm = $urandom;
        in_rs1_addr = 5'($urandom_range(0, 7)); in_rs2_addr = 5'($urandom_range(0, 7));
        in_rd = 5'($urandom_range(0, 7));
        in_rs1_data = $urandom; in_rs2_data = $urandom;
        in_num2_sel = 1'($urandom); in_alu_ctrl = 3'($urandom);
        in_reg_we = ($urandom_range(0, 3) != 0); in_mem_rd = ($urandom_range(0, 2) == 0);
        in_mem_wr = 1'($urandom);
        exm_we = 1'($urandom); exm_rd = 5'($urandom_range(0, 7)); exm_data = $urandom;
        wb_we = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
    endtask

    initial begin
        idle();
        rst = 1;
        @(negedge clk); @(negedge clk);
        rst = 0;
        step();                                     // reset state

        out_ready = 1;                              // back-to-back independent ADDs
        for (int i = 0; i < 6; i++) begin
            instr(32'h100 + 4 * i, 5'd1, 5'd2, 5'(10 + i), 1'b0);
            step();
        end

        instr(32'h200, 5'd5, 5'd0, 5'd9, 1'b0);     // hold rs1=x5, rs2=x0; then drive both buses
        step();
        in_valid = 0; out_ready = 0;
        exm_we = 1; exm_rd = 5; exm_data = 32'h11; wb_we = 1; wb_rd = 5; wb_data = 32'h22;
        step();
        exm_rd = 0; exm_data = 32'hFFFF_FFFF;
        step();
        exm_we = 0; wb_we = 0; out_ready = 1;
        step(); step();

        instr(32'h300, 5'd1, 5'd2, 5'd7, 1'b1);     // load x7, then dependent consumer
        step();
        instr(32'h304, 5'd3, 5'd7, 5'd8, 1'b0);
        step();
        wb_we = 1; wb_rd = 7; wb_data = 32'hDEAD;
        step();
        in_valid = 0; out_ready = 0;
        step();
        wb_we = 0; in_valid = 1; out_ready = 1;
        for (int i = 0; i < 3; i++) step();
        in_valid = 0;
        step();

        instr(32'h400, 5'd1, 5'd2, 5'd3, 1'b0);     // flush with held entry and incoming instr
        out_ready = 0;
        step();
        instr(32'h404, 5'd1, 5'd2, 5'd4, 1'b0);
        flush = 1;
        step();
        flush = 0; in_valid = 0;
        step();

        instr(32'h500, 5'd1, 5'd2, 5'd7, 1'b1);     // backpressure, then reset mid-stall
        out_ready = 1;
        step();
        instr(32'h504, 5'd7, 5'd2, 5'd6, 1'b0);
        out_ready = 0;
        for (int i = 0; i < 3; i++) step();
        rst = 1;
        step();
        rst = 0; in_valid = 0;
        step();

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
